// File: rtl/port_acl_filter.sv
// Per-packet ACL drop filter behind the port parser, one-deep registered output.
// Optional packet counters: define PORT_ACL_FILTER_STATS_EN.
module port_acl_filter #(
    parameter int AXIS_BUS_WIDTH    = 64,
    parameter int AXIS_ID_WIDTH     = 4,
    parameter int AXIS_DEST_WIDTH   = 0,
    parameter int MAX_PACKET_LENGTH = 1522,
    parameter int STAT_CNT_WIDTH    = 32,
    localparam int NUM_BUS_BYTES    = AXIS_BUS_WIDTH / 8,
    localparam int NUM_AXIS_ID      = 2 ** AXIS_ID_WIDTH,
    localparam int EFF_ID_WIDTH     = (AXIS_ID_WIDTH < 1) ? 1 : AXIS_ID_WIDTH,
    localparam int EFF_DEST_WIDTH   = (AXIS_DEST_WIDTH < 1) ? 1 : AXIS_DEST_WIDTH,
    localparam int PACKET_LENGTH_CBITS = $clog2(MAX_PACKET_LENGTH + 1),
    localparam int TUSER_OUT_W      = NUM_AXIS_ID + PACKET_LENGTH_CBITS + 7,
    localparam int TUSER_IN_W       = TUSER_OUT_W + 5
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [AXIS_BUS_WIDTH-1:0]  axis_in_tdata,
    input  logic [TUSER_IN_W-1:0]      axis_in_tuser,
    input  logic [EFF_ID_WIDTH-1:0]    axis_in_tid,
    input  logic [EFF_DEST_WIDTH-1:0]  axis_in_tdest,
    input  logic [NUM_BUS_BYTES-1:0]   axis_in_tkeep,
    input  logic                       axis_in_tlast,
    input  logic                       axis_in_tvalid,
    output logic                       axis_in_tready,
    output logic [AXIS_BUS_WIDTH-1:0]  axis_out_tdata,
    output logic [TUSER_OUT_W-1:0]     axis_out_tuser,
    output logic [EFF_ID_WIDTH-1:0]    axis_out_tid,
    output logic [EFF_DEST_WIDTH-1:0]  axis_out_tdest,
    output logic [NUM_BUS_BYTES-1:0]   axis_out_tkeep,
    output logic                       axis_out_tlast,
    output logic                       axis_out_tvalid,
    input  logic                       axis_out_tready,
    input  logic [4:0]                 drop_flag_mask,
    output logic [STAT_CNT_WIDTH-1:0]  pass_pkt_count,
    output logic [STAT_CNT_WIDTH-1:0]  drop_pkt_count
);

    typedef enum logic [1:0] {
        S_FIRST,
        S_PASS,
        S_DROP
    } state_t;

    state_t r_state;

    logic                      r_out_tvalid;
    logic [AXIS_BUS_WIDTH-1:0] r_out_tdata;
    logic [TUSER_OUT_W-1:0]    r_out_tuser;
    logic [EFF_ID_WIDTH-1:0]   r_out_tid;
    logic [EFF_DEST_WIDTH-1:0] r_out_tdest;
    logic [NUM_BUS_BYTES-1:0]  r_out_tkeep;
    logic                      r_out_tlast;

    logic w_drop_now;
    logic w_drop_beat;
    logic w_out_rdy;
    logic w_hs;
    logic w_fwd;

    // Drop verdict only matters in FIRST; later beats follow the latched state.
    assign w_drop_now  = |(axis_in_tuser[4:0] & drop_flag_mask);
    assign w_drop_beat = (r_state == S_DROP) ||
                         ((r_state == S_FIRST) && w_drop_now);
    assign w_out_rdy   = !r_out_tvalid || axis_out_tready;

    assign axis_in_tready = w_drop_beat ? 1'b1 : w_out_rdy;
    assign w_hs           = axis_in_tvalid && axis_in_tready;
    assign w_fwd          = w_hs && !w_drop_beat;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_FIRST;
        end else if (w_hs) begin
            unique case (r_state)
                S_FIRST: begin
                    if (!axis_in_tlast)
                        r_state <= w_drop_now ? S_DROP : S_PASS;
                end
                S_PASS, S_DROP: begin
                    if (axis_in_tlast)
                        r_state <= S_FIRST;
                end
                default: r_state <= S_FIRST;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_out_tvalid <= 1'b0;
            r_out_tdata  <= '0;
            r_out_tuser  <= '0;
            r_out_tid    <= '0;
            r_out_tdest  <= '0;
            r_out_tkeep  <= '0;
            r_out_tlast  <= 1'b0;
        end else if (w_fwd) begin
            r_out_tvalid <= 1'b1;
            r_out_tdata  <= axis_in_tdata;
            r_out_tuser  <= axis_in_tuser[TUSER_IN_W-1:5];
            r_out_tid    <= axis_in_tid;
            r_out_tdest  <= axis_in_tdest;
            r_out_tkeep  <= axis_in_tkeep;
            r_out_tlast  <= axis_in_tlast;
        end else if (axis_out_tready) begin
            r_out_tvalid <= 1'b0;
        end
    end

    assign axis_out_tvalid = r_out_tvalid;
    assign axis_out_tdata  = r_out_tdata;
    assign axis_out_tuser  = r_out_tuser;
    assign axis_out_tid    = r_out_tid;
    assign axis_out_tdest  = r_out_tdest;
    assign axis_out_tkeep  = r_out_tkeep;
    assign axis_out_tlast  = r_out_tlast;

`ifdef PORT_ACL_FILTER_STATS_EN
    logic [STAT_CNT_WIDTH-1:0] r_pass_cnt;
    logic [STAT_CNT_WIDTH-1:0] r_drop_cnt;

    // Saturating: a stuck-at-max counter is safer than a silent wrap.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_pass_cnt <= '0;
            r_drop_cnt <= '0;
        end else if (w_hs && axis_in_tlast) begin
            if (w_drop_beat) begin
                if (r_drop_cnt != '1)
                    r_drop_cnt <= r_drop_cnt + 1'b1;
            end else begin
                if (r_pass_cnt != '1)
                    r_pass_cnt <= r_pass_cnt + 1'b1;
            end
        end
    end

    assign pass_pkt_count = r_pass_cnt;
    assign drop_pkt_count = r_drop_cnt;
`else
    assign pass_pkt_count = '0;
    assign drop_pkt_count = '0;
`endif

endmodule
